// File: rtl/seg_pkg.sv
// Shared types and 7-segment decode for the scan display.
// Patterns are active-low, bit order g..a.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan prescaler: divides one digit slot into 2**PWM_BITS PWM subslots.
// phase counts subslots; tick marks the last clock of a digit slot.
module seg_scan_timer #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned SCAN_HZ  = 800,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PWM_BITS-1:0] phase,
    output logic                tick
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned NSUB  = 1 << PWM_BITS;
    localparam int unsigned SUB   = DIV / NSUB;
    localparam int unsigned CNT_W = (SUB > 1) ? $clog2(SUB) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SUB - 1);

    if ((DIV % NSUB) != 0 || SUB < 1) begin : g_bad_div
        $error("seg_scan_timer: CLK_HZ/SCAN_HZ must be a non-zero multiple of 2**PWM_BITS");
    end

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PWM_BITS-1:0] phase_q, phase_d;
    logic                cnt_wrap;

    // Next-state: cnt wraps every SUB clocks and then advances phase.
    always_comb begin
        cnt_wrap = (cnt_q == CNT_MAX);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        phase_d  = cnt_wrap ? phase_q + 1'b1 : phase_q;
    end

    // Prescaler registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign tick  = cnt_wrap && (phase_q == '1);

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scan driver with double-buffered loads,
// per-digit decimal points, PWM brightness and a frame-done strobe.
// Optional: SEG_LEADING_ZERO_BLANK_EN blanks digits above the most
// significant non-zero nibble (digit 0 always shown).
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned SCAN_HZ    = 800,
    parameter int unsigned PWM_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
        $error("seg_scan_display: NUM_DIGITS must be in 1..16");
    end

    logic [PWM_BITS-1:0] phase;
    logic                tick;

    seg_scan_timer #(
        .CLK_HZ   (CLK_HZ),
        .SCAN_HZ  (SCAN_HZ),
        .PWM_BITS (PWM_BITS)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .phase (phase),
        .tick  (tick)
    );

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    seg_t                    seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;
    logic                    frame_done_q, frame_done_d;
    logic                    wrap;
    logic [3:0]              nib;
    logic                    dot;
    logic                    lit;
    logic                    blank;

    // Digit index and buffer management; the display buffer only changes
    // on the frame wrap so a frame is never torn. A load on the wrap edge
    // bypasses the pending buffer so it is neither lost nor shown twice.
    always_comb begin
        idx_d        = idx_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        frame_done_d = 1'b0;
        wrap         = tick && (idx_q == IDX_LAST);
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp;
            pend_valid_d = 1'b1;
        end
        if (wrap) begin
            frame_done_d = 1'b1;
            if (load) begin
                disp_val_d   = value;
                disp_dp_d    = dp;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                disp_val_d   = pend_val_q;
                disp_dp_d    = pend_dp_q;
                pend_valid_d = 1'b0;
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;

    // Position of the most significant non-zero nibble (0 if all zero).
    always_comb begin
        msd = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            if (disp_val_q[4*i +: 4] != 4'h0) begin
                msd = IDX_W'(i);
            end
        end
    end

    assign blank = (idx_q > msd);
`else
    assign blank = 1'b0;
`endif

    // Output decode for the current digit, gated by the PWM phase.
    always_comb begin
        nib = '0;
        dot = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib = disp_val_q[4*i +: 4];
                dot = disp_dp_q[i];
            end
        end
        lit      = (phase <= brightness);
        an_d     = '1;
        seg_d    = SEG_BLANK;
        dp_out_d = 1'b1;
        if (lit) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
            seg_d    = blank ? SEG_BLANK : hex_to_seg(nib);
            dp_out_d = ~dot;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_out_q     <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (4 digits, 16 clocks/slot, 4 clocks/subslot).
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic [1:0]  brightness;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_display #(
        .NUM_DIGITS (4),
        .CLK_HZ     (1600),
        .SCAN_HZ    (100),
        .PWM_BITS   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .brightness (brightness),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an         (an),
        .frame_done (frame_done)
    );

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        int         tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         len;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   frame_no = 0;

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i);
        logic [3:0] n;
        n = v[4*i +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        begin
            int msd;
            msd = 0;
            for (int j = 1; j < 4; j++) if (v[4*j +: 4] != 4'h0) msd = j;
            if (i > msd) return 7'h7F;
        end
`endif
        return SEG_TBL[n];
    endfunction

    // Expected lit slots for one whole frame, tagged with that frame's number.
    task automatic push_frame(input int tag, input logic [15:0] v, input logic [3:0] d, input int len);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.tag = tag;
            e.an  = 4'hF ^ (4'b0001 << i);
            e.seg = exp_seg(v, i);
            e.dp  = ~d[i];
            e.len = len;
            sb.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    // Frame counter shared by stimulus and monitor (updated after both sample).
    always @(negedge clk) if (frame_done === 1'b1) frame_no <= frame_no + 1;

    // Monitor: a lit slot is a run of identical non-idle an samples.
    logic       in_run = 1'b0;
    logic [3:0] r_an;
    logic [6:0] r_seg;
    logic       r_dp;
    int         r_len;
    int         r_tag;
    bit         r_stable;

    task automatic finish_run();
        exp_t e;
        while (sb.size() > 0 && sb[0].tag < r_tag) begin
            e = sb.pop_front();
            checks++;
            fails++;
            $display("FAIL slot_missing f%0d: got none expected an=%b seg=%h", e.tag, e.an, e.seg);
        end
        if (sb.size() > 0 && sb[0].tag == r_tag) begin
            e = sb.pop_front();
            checks++;
            if (r_an !== e.an || r_seg !== e.seg || r_dp !== e.dp || r_len != e.len || !r_stable) begin
                fails++;
                $display("FAIL slot f%0d: got an=%b seg=%h dp=%b len=%0d stable=%0d expected an=%b seg=%h dp=%b len=%0d stable=1",
                         r_tag, r_an, r_seg, r_dp, r_len, r_stable, e.an, e.seg, e.dp, e.len);
            end
        end
    endtask

    always @(negedge clk) begin
        if (in_run && an === r_an) begin
            r_len++;
            if (seg_out !== r_seg || dp_out !== r_dp) r_stable = 1'b0;
        end else begin
            if (in_run) finish_run();
            in_run = 1'b0;
            if (an !== 4'hF) begin
                in_run   = 1'b1;
                r_an     = an;
                r_seg    = seg_out;
                r_dp     = dp_out;
                r_len    = 1;
                r_tag    = frame_no;
                r_stable = 1'b1;
            end
        end
        if (an === 4'hF) begin
            checks++;
            if (seg_out !== 7'h7F || dp_out !== 1'b1) begin
                fails++;
                $display("FAIL idle_blank: got seg=%h dp=%b expected seg=7f dp=1", seg_out, dp_out);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Bounded wait for the next frame_done; also checks the frame period.
    task automatic wait_fd(input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        chk("frame_period", n, exp_n);
    endtask

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        value      = '0;
        dp         = '0;
        brightness = 2'd3;
        step(2);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg_out, 7'h7F);
        chk("rst_dp", dp_out, 1'b1);
        chk("rst_fd", frame_done, 1'b0);

        // Frame 0 shows the reset buffer; 1234 is pending for frame 1.
        rst   = 1'b0;
        value = 16'h1234;
        load  = 1'b1;
        push_frame(frame_no, 16'h0000, 4'b0000, 16);
        step(1);
        load  = 1'b0;
        wait_fd(63);
        push_frame(frame_no + 1, 16'h1234, 4'b0000, 16);

        // Mid-frame load must not tear the frame in progress.
        step(20);
        pulse_load(16'hAAAA, 4'b0000);
        wait_fd(43);
        push_frame(frame_no + 1, 16'hAAAA, 4'b0000, 16);

        // Pending 9999, then 5555 loaded on the wrap edge overrides it.
        step(10);
        pulse_load(16'h9999, 4'b0000);
        step(52);
        value = 16'h5555;
        dp    = 4'b0000;
        load  = 1'b1;
        step(1);
        chk("fd_on_coincident_load", frame_done, 1'b1);
        load  = 1'b0;
        push_frame(frame_no + 1, 16'h5555, 4'b0000, 16);
        wait_fd(64);
        push_frame(frame_no + 1, 16'h5555, 4'b0000, 16);

        // Brightness levels.
        wait_fd(64);
        brightness = 2'd0;
        push_frame(frame_no + 1, 16'h5555, 4'b0000, 4);
        wait_fd(64);
        brightness = 2'd1;
        push_frame(frame_no + 1, 16'h5555, 4'b0000, 8);
        pulse_load(16'hC0DE, 4'b0100);
        wait_fd(63);
        brightness = 2'd3;
        push_frame(frame_no + 1, 16'hC0DE, 4'b0100, 16);
        pulse_load(16'hB6F9, 4'b1010);
        wait_fd(63);
        push_frame(frame_no + 1, 16'hB6F9, 4'b1010, 16);
        pulse_load(16'h0007, 4'b0000);
        wait_fd(63);
        push_frame(frame_no + 1, 16'h0007, 4'b0000, 16);
        pulse_load(16'h8787, 4'b0001);
        wait_fd(63);
        push_frame(frame_no + 1, 16'h8787, 4'b0001, 16);
        wait_fd(64);

        // Reset mid-slot with a load still pending: it must be discarded.
        step(25);
        pulse_load(16'h1111, 4'b1111);
        step(3);
        rst = 1'b1;
        step(1);
        chk("midrst_an", an, 4'hF);
        chk("midrst_seg", seg_out, 7'h7F);
        chk("midrst_dp", dp_out, 1'b1);
        chk("midrst_fd", frame_done, 1'b0);
        step(1);
        rst = 1'b0;
        push_frame(frame_no, 16'h0000, 4'b0000, 16);
        wait_fd(64);
        push_frame(frame_no + 1, 16'h0000, 4'b0000, 16);
        wait_fd(64);
        step(3);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
